// File: rtl/cordic_vector_seq.sv
// Iterative vectoring-mode CORDIC: converts a Q4.28 vector (x, y) into a
// gain-corrected magnitude and atan2(y, x), one micro-rotation per clock.
module cordic_vector_seq #(
  parameter int N    = 32,
  parameter int ITER = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] mag,
  output logic [N-1:0] angle
);

  localparam int FRAC = 28;
  localparam logic [N-1:0] HALF_PI = 32'h1921FB54;
  localparam logic signed [2*N-1:0] K_EXT = 64'h0000_0000_09B7_4EDA;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_SCALE} state_t;

  state_t              state;
  logic signed [N-1:0] x_r, y_r, z_r;
  logic [4:0]          i_r;
  logic                zero_flag;

  logic signed [N-1:0]   x_sh, y_sh;
  logic signed [2*N-1:0] prod, prod_sh;

  // atan(2^-i) scaled by 2^28, truncated; shared with the rotation unit.
  function automatic logic [N-1:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_lut = 32'h0C90FDAA;
      5'd1:  atan_lut = 32'h076B19C1;
      5'd2:  atan_lut = 32'h03EB6EBF;
      5'd3:  atan_lut = 32'h01FD5BA9;
      5'd4:  atan_lut = 32'h00FFAADD;
      5'd5:  atan_lut = 32'h007FF556;
      5'd6:  atan_lut = 32'h003FFEAA;
      5'd7:  atan_lut = 32'h001FFFD5;
      5'd8:  atan_lut = 32'h000FFFFA;
      5'd9:  atan_lut = 32'h0007FFFF;
      5'd10: atan_lut = 32'h0003FFFF;
      5'd11: atan_lut = 32'h0001FFFF;
      5'd12: atan_lut = 32'h0000FFFF;
      5'd13: atan_lut = 32'h00007FFF;
      5'd14: atan_lut = 32'h00003FFF;
      5'd15: atan_lut = 32'h00001FFF;
      5'd16: atan_lut = 32'h00000FFF;
      5'd17: atan_lut = 32'h000007FF;
      5'd18: atan_lut = 32'h000003FF;
      5'd19: atan_lut = 32'h000001FF;
      5'd20: atan_lut = 32'h000000FF;
      5'd21: atan_lut = 32'h0000007F;
      5'd22: atan_lut = 32'h0000003F;
      5'd23: atan_lut = 32'h0000001F;
      5'd24: atan_lut = 32'h0000000F;
      5'd25: atan_lut = 32'h00000007;
      5'd26: atan_lut = 32'h00000003;
      5'd27: atan_lut = 32'h00000001;
      default: atan_lut = '0;
    endcase
  endfunction

  always_comb begin
    x_sh    = x_r >>> i_r;
    y_sh    = y_r >>> i_r;
    prod    = $signed({{N{x_r[N-1]}}, x_r}) * K_EXT;
    prod_sh = prod >>> FRAC;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values, e.g. both X and Y updates see the old X/Y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      i_r       <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mag       <= '0;
      angle     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy      <= 1'b1;
            i_r       <= '0;
            zero_flag <= (x_in == '0) && (y_in == '0);
            state     <= S_ITER;
            // Fold left half-plane vectors into the right half-plane.
            if (!x_in[N-1]) begin
              x_r <= x_in;
              y_r <= y_in;
              z_r <= '0;
            end else if (!y_in[N-1]) begin
              x_r <= y_in;
              y_r <= -x_in;
              z_r <= HALF_PI;
            end else begin
              x_r <= -y_in;
              y_r <= x_in;
              z_r <= -HALF_PI;
            end
          end
        end
        S_ITER: begin
          if (!y_r[N-1]) begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_lut(i_r);
          end else begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_lut(i_r);
          end
          i_r <= i_r + 5'd1;
          if (i_r == 5'(ITER - 1)) state <= S_SCALE;
        end
        S_SCALE: begin
          mag   <= N'(prod_sh);
          angle <= zero_flag ? '0 : z_r;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector_seq.sv
// Scoreboard bench for cordic_vector_seq: expected magnitude/angle come from
// real-valued sqrt/atan2, checked by an independent monitor on each done.
module tb_cordic_vector_seq;

  localparam int N    = 32;
  localparam int ITER = 16;
  localparam real SCALE = 268435456.0;
  localparam real MAG_TOL = 32768.0;
  localparam real ANG_TOL = 16384.0;

  logic         clk, rst_n, start;
  logic [N-1:0] x_in, y_in;
  logic         busy, done;
  logic [N-1:0] mag, angle;

  cordic_vector_seq #(.N(N), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .mag(mag), .angle(angle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] x, y;
    real          mag_exp, ang_exp;
    bit           exact;
    int           due;
  } exp_t;

  exp_t sb[$];
  int passes = 0;
  int total  = 0;

  task automatic check(input string name, input bit ok, input string detail);
    total++;
    if (ok) passes++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic real absr(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  // Reference: plain polar conversion of the input vector, in Q4.28 LSBs.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    real xr, yr;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    e.x = x;
    e.y = y;
    e.exact = (x == '0) && (y == '0);
    e.mag_exp = $sqrt(xr * xr + yr * yr);
    e.ang_exp = e.exact ? 0.0 : $atan2(yr, xr) * SCALE / SCALE * SCALE / SCALE;
    e.ang_exp = e.exact ? 0.0 : $atan2(yr / SCALE, xr / SCALE) * SCALE;
    e.due = 0;
    return e;
  endfunction

  // Monitor: compare each presented result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b0,
              $sformatf("got done at cycle %0d, required none", cyc));
      end else begin
        exp_t e;
        real  ma, aa, mt, at;
        e  = sb.pop_front();
        ma = $itor($signed(mag));
        aa = $itor($signed(angle));
        mt = e.exact ? 0.0 : MAG_TOL;
        at = e.exact ? 0.0 : ANG_TOL;
        check("latency", cyc == e.due,
              $sformatf("done at cycle %0d, required %0d", cyc, e.due));
        check("busy_in_done", busy == 1'b0,
              $sformatf("busy=%0b, required 0", busy));
        check("mag", absr(ma - e.mag_exp) <= mt,
              $sformatf("x=%h y=%h got %h, required %0.1f +/- %0.0f",
                        e.x, e.y, mag, e.mag_exp, mt));
        check("angle", absr(aa - e.ang_exp) <= at,
              $sformatf("x=%h y=%h got %h, required %0.1f +/- %0.0f",
                        e.x, e.y, angle, e.ang_exp, at));
      end
    end
  end

  // Issue one conversion from a negedge; returns one negedge after start.
  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    int   n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("busy_timeout", 1'b0, "busy stuck high, required release within 100 cycles");
      return;
    end
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    e     = model(x, y);
    e.due = cyc + ITER + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    x_in  = $urandom;
    y_in  = $urandom;
  endtask

  function automatic logic [N-1:0] rand_q();
    return N'($signed($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
  endfunction

  localparam logic [N-1:0] ONE  = 32'h1000_0000;
  localparam logic [N-1:0] MONE = 32'hF000_0000;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    y_in  = '0;
    #1;
    check("reset_state", !busy && !done && mag == '0 && angle == '0,
          $sformatf("busy=%0b done=%0b mag=%h angle=%h, required all 0",
                    busy, done, mag, angle));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back to back (next start lands in done cycle).
    issue(ONE, '0);
    issue(ONE, ONE);
    issue(MONE, ONE);
    issue(MONE, MONE);
    issue(MONE, '0);
    issue('0, MONE);
    issue('0, '0);
    issue(32'h2000_0000, 32'hE000_0000);

    // Starts pulsed mid-conversion must be ignored.
    issue(32'h0C00_0000, 32'h0500_0000);
    repeat (2) @(negedge clk);
    x_in = MONE; y_in = MONE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    x_in = '0; y_in = ONE; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int k = 0; k < 40; k++) issue(rand_q(), rand_q());

    // Reset during iteration 8: outputs clear at once, no done afterwards.
    issue(ONE, ONE);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", !busy && !done && mag == '0 && angle == '0,
          $sformatf("busy=%0b done=%0b mag=%h angle=%h, required all 0",
                    busy, done, mag, angle));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("no_done_after_reset", sb.size() == 0 && !busy,
          $sformatf("busy=%0b, required 0", busy));
    issue(32'h0800_0000, 32'hF400_0000);

    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    check("drain", sb.size() == 0,
          $sformatf("%0d results outstanding, required 0", sb.size()));
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
